// File: rtl/stall_ctrl_pkg.sv
// Shared types and default parameters for the PC stall/redirect controller.
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int NUM_SRC_DEF   = 2;
  localparam int LEN_W_DEF     = 3;
  localparam int REDIR_CYC_DEF = 3;
  localparam int QUEUE_EN_DEF  = 1;

  // Channel-index width; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module prio_enc #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Redirect/stall controller: a won request forces a jump-target select for
// REDIR_CYC cycles, then holds the PC for the captured length.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int REDIR_CYC = REDIR_CYC_DEF,
  parameter int QUEUE_EN  = QUEUE_EN_DEF,
  localparam int SRC_W    = idx_w(NUM_SRC)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*LEN_W-1:0] len,
  output logic                     pc_en,
  output logic                     jbpc_src,
  output logic                     busy,
  output logic [SRC_W-1:0]         src_id,
  output logic                     overflow
);

  state_e             state_q;
  logic [2:0]         rcnt_q;
  logic [LEN_W-1:0]   hcnt_q;
  logic [LEN_W-1:0]   len_q;
  logic [SRC_W-1:0]   src_q;
  logic               pend_vld_q;
  logic [SRC_W-1:0]   pend_src_q;
  logic [LEN_W-1:0]   pend_len_q;
  logic               pc_en_q, jbpc_q, busy_q, ovf_q;

  logic               win_vld;
  logic [SRC_W-1:0]   win_idx;
  logic [LEN_W-1:0]   win_len;

  prio_enc #(.N(NUM_SRC), .IDX_W(SRC_W)) u_prio (
    .req_i (req),
    .vld_o (win_vld),
    .idx_o (win_idx)
  );

  assign win_len = len[int'(win_idx)*LEN_W +: LEN_W];

  logic             last_cyc;
  logic             go_d;
  logic [SRC_W-1:0] go_src_d;
  logic [LEN_W-1:0] go_len_d;
  logic             pend_set_d, pend_clr_d, ovf_d;

  // Final cycle of a service: a pending or freshly seen request chains
  // straight into a new REDIR so pc_en never rises in between.
  assign last_cyc = ((state_q == REDIR) && (rcnt_q == 3'd0) && (len_q == '0)) ||
                    ((state_q == HOLD)  && (hcnt_q == '0));

  always_comb begin
    go_d       = 1'b0;
    go_src_d   = win_idx;
    go_len_d   = win_len;
    pend_set_d = 1'b0;
    pend_clr_d = 1'b0;
    ovf_d      = 1'b0;
    if (state_q == IDLE) begin
      go_d = win_vld;
    end else if (QUEUE_EN != 0) begin
      if (last_cyc) begin
        if (pend_vld_q) begin
          go_d       = 1'b1;
          go_src_d   = pend_src_q;
          go_len_d   = pend_len_q;
          pend_clr_d = 1'b1;
          pend_set_d = win_vld;
        end else begin
          go_d = win_vld;
        end
      end else if (win_vld) begin
        if (pend_vld_q) ovf_d = 1'b1;
        else            pend_set_d = 1'b1;
      end
    end else begin
      ovf_d = win_vld;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      hcnt_q     <= '0;
      len_q      <= '0;
      src_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_src_q <= '0;
      pend_len_q <= '0;
      pc_en_q    <= 1'b1;
      jbpc_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (pend_set_d) begin
        pend_vld_q <= 1'b1;
        pend_src_q <= win_idx;
        pend_len_q <= win_len;
      end else if (pend_clr_d) begin
        pend_vld_q <= 1'b0;
      end

      if (go_d) begin
        state_q <= REDIR;
        rcnt_q  <= 3'(REDIR_CYC - 1);
        src_q   <= go_src_d;
        len_q   <= go_len_d;
        pc_en_q <= 1'b0;
        jbpc_q  <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          REDIR: begin
            if (rcnt_q != 3'd0) begin
              rcnt_q <= rcnt_q - 3'd1;
            end else if (len_q != '0) begin
              state_q <= HOLD;
              hcnt_q  <= len_q - LEN_W'(1);
              jbpc_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
              pc_en_q <= 1'b1;
              jbpc_q  <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          HOLD: begin
            if (hcnt_q != '0) begin
              hcnt_q <= hcnt_q - LEN_W'(1);
            end else begin
              state_q <= IDLE;
              pc_en_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          IDLE: ;
          default: begin
            state_q <= IDLE;
            pc_en_q <= 1'b1;
            jbpc_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc_en    = pc_en_q;
  assign jbpc_src = jbpc_q;
  assign busy     = busy_q;
  assign src_id   = src_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench: a remaining-stall-cycle model per DUT (queued and
// unqueued) predicts each cycle's outputs; a monitor pops and compares.
module tb_stall_ctrl;

  localparam int NS = 2;
  localparam int LW = 3;
  localparam int RC = 3;

  typedef struct packed {
    logic       pc_en;
    logic       jb;
    logic       busy;
    logic [0:0] src;
    logic       ovf;
  } obs_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NS-1:0] req;
  logic [NS*LW-1:0] len;

  logic       q_pc_en, q_jb, q_busy, q_ovf;
  logic [0:0] q_src;
  logic       n_pc_en, n_jb, n_busy, n_ovf;
  logic [0:0] n_src;

  stall_ctrl #(.NUM_SRC(NS), .LEN_W(LW), .REDIR_CYC(RC), .QUEUE_EN(1)) dut_q (
    .CLK(CLK), .RST(RST), .req(req), .len(len),
    .pc_en(q_pc_en), .jbpc_src(q_jb), .busy(q_busy), .src_id(q_src), .overflow(q_ovf)
  );

  stall_ctrl #(.NUM_SRC(NS), .LEN_W(LW), .REDIR_CYC(RC), .QUEUE_EN(0)) dut_n (
    .CLK(CLK), .RST(RST), .req(req), .len(len),
    .pc_en(n_pc_en), .jbpc_src(n_jb), .busy(n_busy), .src_id(n_src), .overflow(n_ovf)
  );

  always #5 CLK = ~CLK;

  obs_t exp_q[$];
  obs_t exp_n[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Model m=0 has the pending slot, m=1 drops. tot = stall cycles left
  // including the current one; the last hl of them are plain hold cycles.
  int tot[2], hl[2], ms[2], pv[2], ps[2], pl[2];

  function automatic logic [NS*LW-1:0] L(input int l0, input int l1);
    logic [NS*LW-1:0] v;
    v = '0;
    v[0 +: LW]  = LW'(l0);
    v[LW +: LW] = LW'(l1);
    return v;
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      tot[m] = 0; hl[m] = 0; ms[m] = 0; pv[m] = 0; ps[m] = 0; pl[m] = 0;
    end
  endtask

  task automatic mstep(input int m, input logic [NS-1:0] r, output obs_t o);
    int  w, lw;
    bit  seen, last, ovf;
    seen = (r != '0);
    w = 0;
    for (int i = NS - 1; i >= 0; i--) if (r[i]) w = i;
    lw  = seen ? int'(len[w*LW +: LW]) : 0;
    ovf = 1'b0;
    if (tot[m] == 0) begin
      if (seen) begin ms[m] = w; hl[m] = lw; tot[m] = RC + lw; end
    end else begin
      last = (tot[m] == 1);
      tot[m]--;
      if (m == 0) begin
        if (last && pv[m] != 0) begin
          ms[m] = ps[m]; hl[m] = pl[m]; tot[m] = RC + pl[m];
          pv[m] = seen ? 1 : 0; ps[m] = w; pl[m] = lw;
        end else if (last && seen) begin
          ms[m] = w; hl[m] = lw; tot[m] = RC + lw;
        end else if (seen) begin
          if (pv[m] != 0) ovf = 1'b1;
          else begin pv[m] = 1; ps[m] = w; pl[m] = lw; end
        end
      end else begin
        ovf = seen;
      end
    end
    o.pc_en = (tot[m] == 0);
    o.jb    = (tot[m] > hl[m]);
    o.busy  = (tot[m] > 0);
    o.src   = 1'(ms[m]);
    o.ovf   = ovf;
  endtask

  task automatic drive(input logic [NS-1:0] r, input logic [NS*LW-1:0] l);
    obs_t a, b;
    req = r;
    len = l;
    mstep(0, r, a);
    mstep(1, r, b);
    exp_q.push_back(a);
    exp_n.push_back(b);
  endtask

  task automatic cyc(input logic [NS-1:0] r, input logic [NS*LW-1:0] l);
    @(negedge CLK);
    drive(r, l);
  endtask

  task automatic chk(input string tag, input obs_t g, input obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got pc_en=%b jb=%b busy=%b src=%0d ovf=%b, want pc_en=%b jb=%b busy=%b src=%0d ovf=%b",
               tag, cyc_no, g.pc_en, g.jb, g.busy, g.src, g.ovf,
               e.pc_en, e.jb, e.busy, e.src, e.ovf);
    end
  endtask

  task automatic rst_chk(input string tag);
    obs_t r0;
    r0 = '{pc_en: 1'b1, jb: 1'b0, busy: 1'b0, src: 1'b0, ovf: 1'b0};
    chk({tag, "_q"}, {q_pc_en, q_jb, q_busy, q_src, q_ovf}, r0);
    chk({tag, "_n"}, {n_pc_en, n_jb, n_busy, n_src, n_ovf}, r0);
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("queued", {q_pc_en, q_jb, q_busy, q_src, q_ovf}, e);
      end
      if (exp_n.size() > 0) begin
        e = exp_n.pop_front();
        chk("noqueue", {n_pc_en, n_jb, n_busy, n_src, n_ovf}, e);
      end
    end
  end

  initial begin
    req = '0;
    len = '0;
    RST = 1'b1;
    mreset();
    #12;
    rst_chk("por");

    // Request presented on the very edge after release.
    @(negedge CLK);
    RST = 1'b0;
    drive(2'b01, L(2, 5));
    repeat (8) cyc('0, NS*LW'($urandom));

    // Simultaneous requests; channel 1 stays up into the busy window.
    cyc(2'b11, L(0, 4));
    cyc(2'b10, L(0, 4));
    repeat (12) cyc('0, NS*LW'($urandom));

    // Channel 1 pulse during channel 0's hold phase.
    cyc(2'b01, L(3, 0));
    repeat (4) cyc('0, L(0, 0));
    cyc(2'b10, L(0, 2));
    repeat (12) cyc('0, NS*LW'($urandom));

    // Two busy-time requests: one pending, one overflow.
    cyc(2'b01, L(2, 0));
    cyc(2'b10, L(0, 1));
    cyc(2'b10, L(0, 6));
    repeat (12) cyc('0, NS*LW'($urandom));

    // Maximum length.
    cyc(2'b01, L(7, 0));
    repeat (13) cyc('0, NS*LW'($urandom));

    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) cyc(NS'($urandom_range(1, 3)), NS*LW'($urandom));
      else                           cyc('0, NS*LW'($urandom));
    end
    repeat (12) cyc('0, '0);

    // Reset in the middle of a redirect.
    cyc(2'b01, L(3, 3));
    cyc('0, L(3, 3));
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    rst_chk("async");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mreset();
    drive('0, NS*LW'($urandom));
    repeat (10) cyc('0, NS*LW'($urandom));

    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || exp_n.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", exp_q.size(), exp_n.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
